// File: rtl/video_reg_scheduler.sv
// Frame-synchronous colour register scheduler: host writes land in shadow
// registers and are copied to the live registers only at the start of vSync.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | no commit requested; live registers hold their values
//   ARMED  | commit requested; waiting for the next vSync start
//   COMMIT | live registers were loaded last edge; commit_done is high
module video_reg_scheduler #(
    parameter logic       VSYNC_ACTIVE = 1'b0,
    parameter int         AUTO_COMMIT  = 0,
    parameter logic [7:0] ON_RESET     = 8'hFF,
    parameter logic [7:0] OFF_RESET    = 8'h00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        commit_req,
    input  logic        cancel_req,
    input  logic        vSync,
    output logic [7:0]  red_on,
    output logic [7:0]  red_off,
    output logic [7:0]  green_on,
    output logic [7:0]  green_off,
    output logic [7:0]  blue_on,
    output logic [7:0]  blue_off,
    output logic        pending,
    output logic        commit_done,
    output logic [15:0] frame_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       vs_d;
    logic       vs_seen_idle;
    logic       vs_start;
    logic       wr_hit;
    logic       req;
    logic       req_latch;
    logic       commit_fire;

    logic [7:0] sh_red_on;
    logic [7:0] sh_red_off;
    logic [7:0] sh_green_on;
    logic [7:0] sh_green_off;
    logic [7:0] sh_blue_on;
    logic [7:0] sh_blue_off;

    assign wr_hit      = wr_en && (wr_addr < 3'd6);
    assign req         = commit_req || ((AUTO_COMMIT != 0) && wr_hit);
    assign commit_fire = (state == ARMED) && vs_start;

    // A pulse already active at reset release has no seen leading edge, so
    // edges only count once vSync has been observed inactive.
    assign vs_start = vs_seen_idle && (vSync == VSYNC_ACTIVE) && (vs_d != VSYNC_ACTIVE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_d         <= ~VSYNC_ACTIVE;
            vs_seen_idle <= 1'b0;
        end else begin
            vs_d <= vSync;
            if (vSync != VSYNC_ACTIVE) begin
                vs_seen_idle <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_count <= 16'h0000;
        end else if (vs_start) begin
            frame_count <= frame_count + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_red_on    <= ON_RESET;
            sh_red_off   <= OFF_RESET;
            sh_green_on  <= ON_RESET;
            sh_green_off <= OFF_RESET;
            sh_blue_on   <= ON_RESET;
            sh_blue_off  <= OFF_RESET;
        end else if (wr_en) begin
            case (wr_addr)
                3'd0:    sh_red_on    <= wr_data;
                3'd1:    sh_red_off   <= wr_data;
                3'd2:    sh_green_on  <= wr_data;
                3'd3:    sh_green_off <= wr_data;
                3'd4:    sh_blue_on   <= wr_data;
                3'd5:    sh_blue_off  <= wr_data;
                default: ;
            endcase
        end
    end

    // Non-blocking load: a shadow write in the same cycle is not included.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            red_on    <= ON_RESET;
            red_off   <= OFF_RESET;
            green_on  <= ON_RESET;
            green_off <= OFF_RESET;
            blue_on   <= ON_RESET;
            blue_off  <= OFF_RESET;
        end else if (commit_fire) begin
            red_on    <= sh_red_on;
            red_off   <= sh_red_off;
            green_on  <= sh_green_on;
            green_off <= sh_green_off;
            blue_on   <= sh_blue_on;
            blue_off  <= sh_blue_off;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (vs_start) begin
                    state_nx = COMMIT;
                end else if (cancel_req && !req) begin
                    state_nx = IDLE;
                end
            end
            COMMIT: begin
                if (req || (req_latch && !cancel_req)) begin
                    state_nx = ARMED;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            req_latch   <= 1'b0;
            pending     <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            state       <= state_nx;
            req_latch   <= commit_fire && req;
            pending     <= (state_nx == ARMED);
            commit_done <= (state_nx == COMMIT);
        end
    end

endmodule

// File: tb/tb_video_reg_scheduler.sv
// Directed bench for video_reg_scheduler: a vector table for the commit/cancel
// protocol plus hand-written sequences for write races, auto-commit and wrap.
`timescale 1ns/1ps
module tb_video_reg_scheduler;

    logic clk = 1'b0;
    logic clk_w = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    always #2 clk_w = ~clk_w;

    int tests = 0;
    int fails = 0;

    // main instance, AUTO_COMMIT=0
    logic        we, cr, cx, vs;
    logic [2:0]  addr;
    logic [7:0]  data;
    logic [7:0]  ron, roff, gon, goff, bon, boff;
    logic        pend, done;
    logic [15:0] fc;

    video_reg_scheduler dut (
        .clk(clk), .rstn(rstn), .wr_en(we), .wr_addr(addr), .wr_data(data),
        .commit_req(cr), .cancel_req(cx), .vSync(vs),
        .red_on(ron), .red_off(roff), .green_on(gon), .green_off(goff),
        .blue_on(bon), .blue_off(boff), .pending(pend), .commit_done(done),
        .frame_count(fc)
    );

    // auto-commit instance
    logic        b_we, b_cr, b_cx, b_vs;
    logic [2:0]  b_addr;
    logic [7:0]  b_data;
    logic [7:0]  b_ron, b_roff, b_gon, b_goff, b_bon, b_boff;
    logic        b_pend, b_done;
    logic [15:0] b_fc;

    video_reg_scheduler #(.AUTO_COMMIT(1)) dut_b (
        .clk(clk), .rstn(rstn), .wr_en(b_we), .wr_addr(b_addr), .wr_data(b_data),
        .commit_req(b_cr), .cancel_req(b_cx), .vSync(b_vs),
        .red_on(b_ron), .red_off(b_roff), .green_on(b_gon), .green_off(b_goff),
        .blue_on(b_bon), .blue_off(b_boff), .pending(b_pend), .commit_done(b_done),
        .frame_count(b_fc)
    );

    // frame counter wrap instance on a faster clock
    logic        w_vs;
    logic [7:0]  w_ron, w_roff, w_gon, w_goff, w_bon, w_boff;
    logic        w_pend, w_done;
    logic [15:0] w_fc;

    video_reg_scheduler dut_w (
        .clk(clk_w), .rstn(rstn), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(8'h00),
        .commit_req(1'b0), .cancel_req(1'b0), .vSync(w_vs),
        .red_on(w_ron), .red_off(w_roff), .green_on(w_gon), .green_off(w_goff),
        .blue_on(w_bon), .blue_off(w_boff), .pending(w_pend), .commit_done(w_done),
        .frame_count(w_fc)
    );

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic        cr;
        logic        cx;
        logic        vs;
        logic        exp_pend;
        logic        exp_done;
        logic [7:0]  exp_gon;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t tbl[24];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wtick();
        @(posedge clk_w);
        #1;
    endtask

    task automatic idle_a();
        we = 1'b0; addr = 3'd0; data = 8'h00; cr = 1'b0; cx = 1'b0;
    endtask

    function automatic vec_t mk(input logic v_we, input logic [2:0] v_addr, input logic [7:0] v_data,
                                input logic v_cr, input logic v_cx, input logic v_vs,
                                input logic e_p, input logic e_d, input logic [7:0] e_g,
                                input logic [15:0] e_f);
        vec_t v;
        v.we = v_we; v.addr = v_addr; v.data = v_data; v.cr = v_cr; v.cx = v_cx; v.vs = v_vs;
        v.exp_pend = e_p; v.exp_done = e_d; v.exp_gon = e_g; v.exp_fc = e_f;
        return v;
    endfunction

    initial begin
        //                we    addr  data   cr    cx    vs    pend  done  gon    fc
        tbl[0]  = mk(1'b1, 3'd2, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 16'd0);
        tbl[1]  = mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 16'd0);
        tbl[2]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 16'd0);
        tbl[3]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 16'd1);
        tbl[4]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 16'd1);
        tbl[5]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 16'd1);
        tbl[6]  = mk(1'b1, 3'd2, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 16'd1);
        tbl[7]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 16'd1);
        tbl[8]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 16'd2);
        tbl[9]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 16'd2);
        tbl[10] = mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 16'd2);
        tbl[11] = mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 16'd2);
        tbl[12] = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 16'd3);
        tbl[13] = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 16'd3);
        tbl[14] = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 16'd3);
        tbl[15] = mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 16'd3);
        tbl[16] = mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 16'd4);
        tbl[17] = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 16'd4);
        tbl[18] = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 16'd4);
        tbl[19] = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 16'd4);
        tbl[20] = mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 16'd4);
        tbl[21] = mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 16'd5);
        tbl[22] = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 16'd5);
        tbl[23] = mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 16'd5);

        idle_a();
        vs = 1'b0;
        b_we = 1'b0; b_addr = 3'd0; b_data = 8'h00; b_cr = 1'b0; b_cx = 1'b0; b_vs = 1'b1;
        w_vs = 1'b1;

        // reset release with vSync held active
        #23 rstn = 1'b1;
        tick(); tick(); tick();
        check("rst_red_on", {8'h00, ron}, 16'h00FF);
        check("rst_red_off", {8'h00, roff}, 16'h0000);
        check("rst_pending", {15'd0, pend}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_fc_vs_held", fc, 16'd0);
        vs = 1'b1;
        tick();
        check("rst_fc_after_release", fc, 16'd0);

        for (int i = 0; i < 24; i++) begin
            we = tbl[i].we; addr = tbl[i].addr; data = tbl[i].data;
            cr = tbl[i].cr; cx = tbl[i].cx; vs = tbl[i].vs;
            tick();
            check($sformatf("vec%0d_pending", i), {15'd0, pend}, {15'd0, tbl[i].exp_pend});
            check($sformatf("vec%0d_done", i), {15'd0, done}, {15'd0, tbl[i].exp_done});
            check($sformatf("vec%0d_green_on", i), {8'h00, gon}, {8'h00, tbl[i].exp_gon});
            check($sformatf("vec%0d_fc", i), fc, tbl[i].exp_fc);
        end
        idle_a();

        // shadow write racing the vs_start cycle
        we = 1'b1; addr = 3'd0; data = 8'h22; tick();
        idle_a(); cr = 1'b1; tick();
        check("race_armed", {15'd0, pend}, 16'd1);
        idle_a(); we = 1'b1; addr = 3'd0; data = 8'h11; vs = 1'b0; tick();
        check("race_red_on_old", {8'h00, ron}, 16'h0022);
        check("race_done", {15'd0, done}, 16'd1);
        idle_a(); vs = 1'b1; tick();
        check("race_red_on_hold", {8'h00, ron}, 16'h0022);
        cr = 1'b1; tick();
        idle_a(); vs = 1'b0; tick();
        check("race_red_on_new", {8'h00, ron}, 16'h0011);
        check("race_fc", fc, 16'd7);
        vs = 1'b1; tick();

        // auto-commit instance: addr7 ignored, addr5 arms
        b_we = 1'b1; b_addr = 3'd7; b_data = 8'hFF; tick();
        b_we = 1'b0;
        check("auto_a7_pending", {15'd0, b_pend}, 16'd0);
        check("auto_a7_red_on", {8'h00, b_ron}, 16'h00FF);
        b_we = 1'b1; b_addr = 3'd5; b_data = 8'hA5; tick();
        b_we = 1'b0;
        check("auto_a5_pending", {15'd0, b_pend}, 16'd1);
        check("auto_a5_blue_off_pre", {8'h00, b_boff}, 16'h0000);
        b_vs = 1'b0; tick();
        check("auto_blue_off", {8'h00, b_boff}, 16'h00A5);
        check("auto_done", {15'd0, b_done}, 16'd1);
        b_vs = 1'b1; tick();
        b_we = 1'b1; b_addr = 3'd7; b_data = 8'hFF; tick();
        b_we = 1'b0;
        check("auto_a7_no_arm", {15'd0, b_pend}, 16'd0);
        b_vs = 1'b0; tick();
        check("auto_a7_no_done", {15'd0, b_done}, 16'd0);
        check("auto_a7_blue_off", {8'h00, b_boff}, 16'h00A5);
        check("auto_fc", b_fc, 16'd2);
        b_vs = 1'b1; tick();

        // reset while armed discards the commit
        cr = 1'b1; tick();
        idle_a();
        check("midrst_armed", {15'd0, pend}, 16'd1);
        rstn = 1'b0;
        #1;
        check("midrst_pending", {15'd0, pend}, 16'd0);
        check("midrst_red_on", {8'h00, ron}, 16'h00FF);
        check("midrst_fc", fc, 16'd0);
        tick();
        rstn = 1'b1;
        tick();
        vs = 1'b0; tick();
        check("midrst_no_commit", {15'd0, done}, 16'd0);
        check("midrst_green_on", {8'h00, gon}, 16'h00FF);
        vs = 1'b1;

        // frame counter wrap
        wtick();
        for (int i = 0; i < 65535; i++) begin
            w_vs = 1'b0; wtick();
            w_vs = 1'b1; wtick();
        end
        check("wrap_ffff", w_fc, 16'hFFFF);
        w_vs = 1'b0; wtick();
        check("wrap_zero", w_fc, 16'h0000);
        w_vs = 1'b1; wtick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
